// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the axi_lite command arbiter.
// The optional watchdog is enabled by defining ARB_TIMEOUT_EN.
package axi_lite_arb_pkg;

   localparam int BE_WIDTH   = 4;
   localparam int DATA_WIDTH = 32;

   // Reported in o_req_status when the watchdog abandons a command
   localparam logic [DATA_WIDTH-1:0] TIMEOUT_STATUS = 32'hDEAD_0001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_ACK  = 2'd2,
      ST_REL  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/axi_lite_cmd_arbiter_rr_arbiter.sv
// Rotate-priority encoder: the lowest set request at or above ptr wins,
// otherwise the lowest set request overall (wrap-around).
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic [NUM_REQ-1:0] low_mask;
   logic [NUM_REQ-1:0] upper_req;
   logic [NUM_REQ-1:0] pick_src;

   always_comb begin
      low_mask  = ({{(NUM_REQ-1){1'b0}}, 1'b1} << ptr) - 1'b1;
      upper_req = req & ~low_mask;
      pick_src  = (upper_req != '0) ? upper_req : req;
      // Isolate the lowest set bit
      grant     = pick_src & (~pick_src + 1'b1);
   end

endmodule

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin sharing of one axi_lite_master command port among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to add a watchdog that abandons unanswered commands.
module axi_lite_cmd_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             i_req_en,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
   input  logic [NUM_REQ-1:0]             i_req_wr_rd,
   input  logic [NUM_REQ*BE_WIDTH-1:0]    i_req_byte_en,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]             o_req_ack,
   output logic [NUM_REQ-1:0]             o_req_error,
   output logic [DATA_WIDTH-1:0]          o_req_data,
   output logic [DATA_WIDTH-1:0]          o_req_status,
   output logic [NUM_REQ-1:0]             o_grant,
   output logic                           o_cmd_en,
   output logic [ADDR_WIDTH-1:0]          o_cmd_addr,
   output logic                           o_cmd_wr_rd,
   output logic [BE_WIDTH-1:0]            o_cmd_byte_en,
   output logic [DATA_WIDTH-1:0]          o_cmd_data,
   input  logic                           i_cmd_ack,
   input  logic                           i_cmd_error,
   input  logic [DATA_WIDTH-1:0]          i_cmd_data,
   input  logic [DATA_WIDTH-1:0]          i_cmd_status
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Both sides use a 4-phase level handshake: en rises, ack rises, en falls,
   // ack falls. A new command is only launched once the master has dropped ack.
   arb_state_e              state_q, state_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [PTR_W-1:0]        gidx_q, gidx_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic                    cmd_en_q, cmd_en_d;
   logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
   logic                    cmd_wr_q, cmd_wr_d;
   logic [BE_WIDTH-1:0]     cmd_be_q, cmd_be_d;
   logic [DATA_WIDTH-1:0]   cmd_data_q, cmd_data_d;
   logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
   logic [NUM_REQ-1:0]      req_err_q, req_err_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   status_q, status_d;

   logic [NUM_REQ-1:0]      arb_grant;
   logic [PTR_W-1:0]        win_idx;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic                    win_wr;
   logic [BE_WIDTH-1:0]     win_be;
   logic [DATA_WIDTH-1:0]   win_data;
   logic                    winner_en;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req   (i_req_en),
      .ptr   (ptr_q),
      .grant (arb_grant)
   );

   always_comb begin
      win_idx  = '0;
      win_addr = '0;
      win_wr   = 1'b0;
      win_be   = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            win_idx  = PTR_W'(i);
            win_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wr   = i_req_wr_rd[i];
            win_be   = i_req_byte_en[i*BE_WIDTH +: BE_WIDTH];
            win_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign winner_en = |(i_req_en & grant_q);

`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMO_W-1:0] tmo_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst || state_q != ST_CMD) tmo_cnt_q <= '0;
      else                           tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end
`endif

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      grant_d    = grant_q;
      cmd_en_d   = cmd_en_q;
      cmd_addr_d = cmd_addr_q;
      cmd_wr_d   = cmd_wr_q;
      cmd_be_d   = cmd_be_q;
      cmd_data_d = cmd_data_q;
      req_ack_d  = req_ack_q;
      req_err_d  = req_err_q;
      rdata_d    = rdata_q;
      status_d   = status_q;
      case (state_q)
         ST_IDLE: begin
            if (|i_req_en) begin
               grant_d    = arb_grant;
               gidx_d     = win_idx;
               cmd_addr_d = win_addr;
               cmd_wr_d   = win_wr;
               cmd_be_d   = win_be;
               cmd_data_d = win_data;
               cmd_en_d   = 1'b1;
               state_d    = ST_CMD;
            end
         end
         ST_CMD: begin
            // The winner dropping its enable here is ignored on purpose
            if (i_cmd_ack) begin
               cmd_en_d  = 1'b0;
               req_ack_d = grant_q;
               req_err_d = i_cmd_error ? grant_q : '0;
               rdata_d   = i_cmd_data;
               status_d  = i_cmd_status;
               state_d   = ST_ACK;
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               cmd_en_d  = 1'b0;
               req_ack_d = grant_q;
               req_err_d = grant_q;
               status_d  = TIMEOUT_STATUS;
               state_d   = ST_ACK;
            end
`endif
         end
         ST_ACK: begin
            if (!winner_en) begin
               req_ack_d = '0;
               req_err_d = '0;
               ptr_d     = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
               state_d   = ST_REL;
            end
         end
         ST_REL: begin
            if (!i_cmd_ack) begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         gidx_q     <= '0;
         grant_q    <= '0;
         cmd_en_q   <= 1'b0;
         cmd_addr_q <= '0;
         cmd_wr_q   <= 1'b0;
         cmd_be_q   <= '0;
         cmd_data_q <= '0;
         req_ack_q  <= '0;
         req_err_q  <= '0;
         rdata_q    <= '0;
         status_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         grant_q    <= grant_d;
         cmd_en_q   <= cmd_en_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_wr_q   <= cmd_wr_d;
         cmd_be_q   <= cmd_be_d;
         cmd_data_q <= cmd_data_d;
         req_ack_q  <= req_ack_d;
         req_err_q  <= req_err_d;
         rdata_q    <= rdata_d;
         status_q   <= status_d;
      end
   end

   assign o_req_ack     = req_ack_q;
   assign o_req_error   = req_err_q;
   assign o_req_data    = rdata_q;
   assign o_req_status  = status_q;
   assign o_grant       = grant_q;
   assign o_cmd_en      = cmd_en_q;
   assign o_cmd_addr    = cmd_addr_q;
   assign o_cmd_wr_rd   = cmd_wr_q;
   assign o_cmd_byte_en = cmd_be_q;
   assign o_cmd_data    = cmd_data_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Bench for axi_lite_cmd_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model. Define ARB_TIMEOUT_EN for the watchdog case.
module tb_axi_lite_cmd_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     i_req_en;
   logic [N*AW-1:0]  i_req_addr;
   logic [N-1:0]     i_req_wr_rd;
   logic [N*4-1:0]   i_req_byte_en;
   logic [N*32-1:0]  i_req_data;
   logic [N-1:0]     o_req_ack;
   logic [N-1:0]     o_req_error;
   logic [31:0]      o_req_data;
   logic [31:0]      o_req_status;
   logic [N-1:0]     o_grant;
   logic             o_cmd_en;
   logic [AW-1:0]    o_cmd_addr;
   logic             o_cmd_wr_rd;
   logic [3:0]       o_cmd_byte_en;
   logic [31:0]      o_cmd_data;
   logic             i_cmd_ack;
   logic             i_cmd_error;
   logic [31:0]      i_cmd_data;
   logic [31:0]      i_cmd_status;

   axi_lite_cmd_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW)
`ifdef ARB_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req_en      (i_req_en),
      .i_req_addr    (i_req_addr),
      .i_req_wr_rd   (i_req_wr_rd),
      .i_req_byte_en (i_req_byte_en),
      .i_req_data    (i_req_data),
      .o_req_ack     (o_req_ack),
      .o_req_error   (o_req_error),
      .o_req_data    (o_req_data),
      .o_req_status  (o_req_status),
      .o_grant       (o_grant),
      .o_cmd_en      (o_cmd_en),
      .o_cmd_addr    (o_cmd_addr),
      .o_cmd_wr_rd   (o_cmd_wr_rd),
      .o_cmd_byte_en (o_cmd_byte_en),
      .o_cmd_data    (o_cmd_data),
      .i_cmd_ack     (i_cmd_ack),
      .i_cmd_error   (i_cmd_error),
      .i_cmd_data    (i_cmd_data),
      .i_cmd_status  (i_cmd_status)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference model: what each requester asked for, pending set, rr pointer
   logic [31:0] m_addr[N];
   logic        m_wr[N];
   logic [3:0]  m_be[N];
   logic [31:0] m_data[N];
   logic [N-1:0] pend;
   int          m_ptr;
   logic [N-1:0] exp_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_winner(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (p[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Driver tasks
   task automatic load_req(input int r, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
      m_addr[r] = a; m_wr[r] = w; m_be[r] = b; m_data[r] = d;
      i_req_addr[r*AW +: AW]  = a;
      i_req_wr_rd[r]          = w;
      i_req_byte_en[r*4 +: 4] = b;
      i_req_data[r*32 +: 32]  = d;
      i_req_en[r] = 1'b1;
      pend[r]     = 1'b1;
   endtask

   task automatic load_rand(input int r);
      load_req(r, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
   endtask

   task automatic drop_req(input int r);
      i_req_en[r] = 1'b0;
      pend[r]     = 1'b0;
   endtask

   task automatic wait_cmd_en(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (o_cmd_en !== 1'b1 && lat < 20);
   endtask

   // One full command: grant, master response, requester release, master release
   task automatic run_txn(input int ack_dly, input logic [31:0] rd, input logic [31:0] st,
                          input logic er, input int hold, input logic reraise,
                          output int lat, output int w);
      w = exp_winner(pend, m_ptr);
      lat = 0;
      if (w < 0) begin
         chk("pending_request", 64'd0, 64'd1);
         return;
      end
      exp_q.push_back(N'(1) << w);
      wait_cmd_en(lat);
      if (o_cmd_en !== 1'b1) begin
         chk("cmd_en_seen", {63'd0, o_cmd_en}, 64'd1);
         void'(exp_q.pop_front());
         return;
      end
      chk("grant", o_grant, exp_q.pop_front());
      chk("cmd_addr", o_cmd_addr, m_addr[w]);
      chk("cmd_wr_rd", o_cmd_wr_rd, m_wr[w]);
      chk("cmd_byte_en", o_cmd_byte_en, m_be[w]);
      chk("cmd_data", o_cmd_data, m_data[w]);
      chk("req_ack_in_cmd", o_req_ack, 0);
      // Winner inputs change while the command is in flight; the latched copy must hold
      i_req_addr[w*AW +: AW] = ~m_addr[w];
      i_req_data[w*32 +: 32] = ~m_data[w];
      repeat (ack_dly) begin
         @(negedge clk);
         chk("cmd_en_hold", o_cmd_en, 1);
      end
      chk("cmd_addr_stable", o_cmd_addr, m_addr[w]);
      chk("cmd_data_stable", o_cmd_data, m_data[w]);
      i_cmd_ack = 1'b1; i_cmd_data = rd; i_cmd_status = st; i_cmd_error = er;
      @(negedge clk);
      chk("cmd_en_drop", o_cmd_en, 0);
      chk("req_ack", o_req_ack, N'(1) << w);
      chk("req_error", o_req_error, er ? (N'(1) << w) : '0);
      chk("req_data", o_req_data, rd);
      chk("req_status", o_req_status, st);
      i_cmd_data = $urandom; i_cmd_status = $urandom;
      drop_req(w);
      m_ptr = (w + 1) % N;
      @(negedge clk);
      chk("ack_clear", o_req_ack, 0);
      chk("error_clear", o_req_error, 0);
      chk("grant_in_rel", o_grant, N'(1) << w);
      chk("req_data_hold", o_req_data, rd);
      if (reraise) load_rand(w);
      repeat (hold) begin
         @(negedge clk);
         chk("no_cmd_in_rel", o_cmd_en, 0);
      end
      i_cmd_ack = 1'b0; i_cmd_error = 1'b0;
      @(negedge clk);
      chk("grant_idle", o_grant, 0);
      chk("cmd_en_idle", o_cmd_en, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"}, o_req_ack, 0);
      chk({tag, "_error"}, o_req_error, 0);
      chk({tag, "_rdata"}, o_req_data, 0);
      chk({tag, "_status"}, o_req_status, 0);
      chk({tag, "_grant"}, o_grant, 0);
      chk({tag, "_cmd_en"}, o_cmd_en, 0);
      chk({tag, "_cmd_fields"}, {o_cmd_addr, o_cmd_wr_rd, o_cmd_byte_en}, 0);
      chk({tag, "_cmd_data"}, o_cmd_data, 0);
   endtask

   int lat, w, cnt;

   initial begin
      rst = 1'b0;
      i_req_en = '0; i_req_addr = '0; i_req_wr_rd = '0; i_req_byte_en = '0; i_req_data = '0;
      i_cmd_ack = 1'b0; i_cmd_error = 1'b0; i_cmd_data = '0; i_cmd_status = '0;
      pend = '0; m_ptr = 0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;

      // All four requesting continuously: grants rotate 0,1,2,3,0
      for (int r = 0; r < N; r++) load_rand(r);
      for (int t = 0; t < 5; t++) begin
         run_txn($urandom_range(0, 3), $urandom, $urandom, 1'b0, $urandom_range(0, 2), 1'b1, lat, w);
         chk("rotation_order", w, t % N);
      end
      for (int r = 0; r < N; r++) drop_req(r);
      @(negedge clk);
      m_ptr = 1;

      // Single write from requester 1, master acks 3 clk later
      load_req(1, 32'h10, 1'b1, 4'hF, 32'hA5A5_A5A5);
      run_txn(3, 32'h0, 32'h0000_0001, 1'b0, 0, 1'b0, lat, w);
      chk("single_latency", lat, 1);

      // Master holds ack 5 clk after en falls
      load_rand(0);
      run_txn(1, $urandom, $urandom, 1'b0, 5, 1'b0, lat, w);

      // Read with error from requester 2
      load_req(2, 32'h0000_0040, 1'b0, 4'hF, 32'h0);
      run_txn(2, 32'h1234_5678, 32'h0000_0002, 1'b1, 0, 1'b0, lat, w);

      // Reset during CMD: pointer (now 3) must return to 0
      load_rand(3);
      wait_cmd_en(lat);
      chk("pre_reset_grant", o_grant, 4'b1000);
      rst = 1'b0;
      for (int r = 0; r < N; r++) drop_req(r);
      @(negedge clk);
      chk_all_zero("mid_reset");
      rst = 1'b1;
      m_ptr = 0;
      load_rand(2);
      load_rand(3);
      run_txn(1, $urandom, $urandom, 1'b0, 0, 1'b0, lat, w);
      chk("post_reset_winner", w, 2);
      run_txn(0, $urandom, $urandom, 1'b1, 1, 1'b0, lat, w);

      // Randomized traffic
      for (int t = 0; t < 30; t++) begin
         for (int r = 0; r < N; r++)
            if (!pend[r] && $urandom_range(0, 2) == 0) load_rand(r);
         if (pend == '0) load_rand($urandom_range(0, N - 1));
         run_txn($urandom_range(0, 4), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, w);
      end
      for (int r = 0; r < N; r++) drop_req(r);
      @(negedge clk);

`ifdef ARB_TIMEOUT_EN
      // Master never acks: watchdog fires 16 clk after o_cmd_en
      load_rand(1);
      load_rand(3);
      w = exp_winner(pend, m_ptr);
      wait_cmd_en(lat);
      chk("tmo_grant", o_grant, N'(1) << w);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (o_req_ack == '0 && cnt < 64);
      chk("tmo_latency", cnt, 16);
      chk("tmo_ack", o_req_ack, N'(1) << w);
      chk("tmo_error", o_req_error, N'(1) << w);
      chk("tmo_status", o_req_status, 32'hDEAD_0001);
      chk("tmo_cmd_en", o_cmd_en, 0);
      drop_req(w);
      m_ptr = (w + 1) % N;
      @(negedge clk);
      chk("tmo_ack_clear", o_req_ack, 0);
      // Late master ack is absorbed before the next grant
      i_cmd_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("tmo_late_ack_no_cmd", o_cmd_en, 0);
      end
      i_cmd_ack = 1'b0;
      run_txn(1, $urandom, $urandom, 1'b0, 0, 1'b0, lat, w);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
